// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one ram_dual instance between two requesters (A and B). Each
// requester issues read or write commands over a req/gnt handshake; at most
// one command is accepted per cycle. The RAM write and read ports are driven
// from registers. Read data comes back two cycles after the transfer and is
// steered to the requester that issued the read.
//
// Configuration macro: RAM_ARB_RR_EN
//   defined   -> round-robin on contention (grant the requester not granted last)
//   undefined -> fixed priority on contention (A always wins)
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    requester A command
//   a_gnt                        A command accepted this cycle (combinational)
//   a_rvalid/a_rdata             A read return (rdata is 0 when rvalid is low)
//   b_*                          same set for requester B
//   ram_data/ram_write_addr/ram_we/ram_read_addr   registered RAM controls
//   ram_q                        RAM read data
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

`ifdef RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic                  last;
  logic                  xfer;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  p1_valid, p1_tag;
  logic                  p2_valid, p2_tag;

  // Grant logic. In fixed-priority builds RR_EN is 0, so A always wins
  // contention even though last is still tracked.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        if (RR_EN && (last == OWN_A)) b_gnt = 1'b1;
        else                          a_gnt = 1'b1;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Command of whichever requester was granted; grants are one-hot.
  always_comb begin
    xfer      = a_gnt | b_gnt;
    sel_we    = b_gnt ? b_we    : a_we;
    sel_addr  = b_gnt ? b_addr  : a_addr;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
  end

  // RAM port registers, priority pointer and read tag pipeline. p1 lines up
  // with ram_read_addr, p2 with the registered ram_q coming out of the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we         <= 1'b0;
      ram_data       <= '0;
      ram_write_addr <= '0;
      ram_read_addr  <= '0;
      last           <= OWN_B;
      p1_valid       <= 1'b0;
      p1_tag         <= OWN_A;
      p2_valid       <= 1'b0;
      p2_tag         <= OWN_A;
    end else begin
      ram_we <= xfer && sel_we;
      if (xfer && sel_we) begin
        ram_write_addr <= sel_addr;
        ram_data       <= sel_wdata;
      end
      if (xfer && !sel_we) ram_read_addr <= sel_addr;
      if (xfer) last <= b_gnt ? OWN_B : OWN_A;
      p1_valid <= xfer && !sel_we;
      p1_tag   <= b_gnt ? OWN_B : OWN_A;
      p2_valid <= p1_valid;
      p2_tag   <= p1_tag;
    end
  end

  // Read return steering; data is forced to 0 for the requester not being served.
  always_comb begin
    a_rvalid = p2_valid && (p2_tag == OWN_A);
    b_rvalid = p2_valid && (p2_tag == OWN_B);
    a_rdata  = a_rvalid ? ram_q : '0;
    b_rdata  = b_rvalid ? ram_q : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter with a behavioural ram_dual model attached.
// Reads are scored against a reference memory updated in command order.
module tb_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [AW-1:0] ram_write_addr, ram_read_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_write_addr(ram_write_addr), .ram_we(ram_we),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  // Behavioural ram_dual: registered read, both clocks tied to clk.
  logic [DW-1:0] ram_mem [64] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_write_addr] <= ram_data;
    ram_q <= ram_mem[ram_read_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [7:0]  data;
    int          due;
  } rd_t;
  rd_t sb[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: grant policy, pending write, memory contents in command order.
  logic          ref_last = 1'b1;
  logic [7:0]    ref_mem [64] = '{default: '0};
  logic          pend_we = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  logic          exp_a, exp_b, nxt_we;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_data;

  always @(negedge clk) begin
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        exp_a = !RR || (ref_last == 1'b1);
        exp_b = !exp_a;
      end else begin
        exp_a = a_req;
        exp_b = b_req;
      end
    end
    checkOutput("a_gnt", 32'(a_gnt), 32'(exp_a));
    checkOutput("b_gnt", 32'(b_gnt), 32'(exp_b));
    checkOutput("ram_we", 32'(ram_we), 32'(pend_we));
    if (pend_we) begin
      checkOutput("ram_write_addr", 32'(ram_write_addr), 32'(pend_addr));
      checkOutput("ram_data", 32'(ram_data), 32'(pend_data));
    end
    nxt_we = 1'b0;
    nxt_addr = pend_addr;
    nxt_data = pend_data;
    if (rst_n && a_req && a_gnt) begin
      ref_last = 1'b0;
      if (a_we) begin
        ref_mem[a_addr] = a_wdata;
        nxt_we = 1'b1; nxt_addr = a_addr; nxt_data = a_wdata;
      end else sb.push_back('{owner: 1'b0, data: ref_mem[a_addr], due: cyc + 2});
    end
    if (rst_n && b_req && b_gnt) begin
      ref_last = 1'b1;
      if (b_we) begin
        ref_mem[b_addr] = b_wdata;
        nxt_we = 1'b1; nxt_addr = b_addr; nxt_data = b_wdata;
      end else sb.push_back('{owner: 1'b1, data: ref_mem[b_addr], due: cyc + 2});
    end
    if (!rst_n) begin
      ref_last = 1'b1;
      nxt_we = 1'b0;
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end
    pend_we = nxt_we;
    pend_addr = nxt_addr;
    pend_data = nxt_data;
  end

  // Monitor: pops one expected read per presented rvalid.
  rd_t e;
  always @(negedge clk) begin
    if (a_rvalid && b_rvalid) checkOutput("rvalid_both", 32'd1, 32'd0);
    if (a_rvalid || b_rvalid) begin
      if (sb.size() == 0) checkOutput("rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        checkOutput("rvalid_owner", 32'(b_rvalid), 32'(e.owner));
        checkOutput("rdata", 32'(a_rvalid ? a_rdata : b_rdata), 32'(e.data));
        checkOutput("rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("rvalid_missing", 32'd0, 32'd1);
    end
    if (!a_rvalid) checkOutput("a_rdata_idle", 32'(a_rdata), 32'd0);
    if (!b_rvalid) checkOutput("b_rdata_idle", 32'(b_rdata), 32'd0);
  end

  logic a_xfer = 1'b0, b_xfer = 1'b0;

  task automatic applyStimulus(input logic ar, input logic awe, input logic [AW-1:0] aa,
                               input logic [DW-1:0] ad, input logic br, input logic bwe,
                               input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_we = awe; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bwe; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    a_xfer = a_req && a_gnt;
    b_xfer = b_req && b_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  logic [AW-1:0] pool [9];

  initial begin
    pool = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h12, 6'h20, 6'h21, 6'h3E, 6'h3F};
    @(posedge clk);
    #1;
    // Reset held with A requesting: no grants, no writes, no read returns.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 6'h00, 8'h00, 0, 0, '0, '0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 6'h00, 8'h00, 0, 0, '0, '0);
    // Write then read back.
    applyStimulus(1, 1, 6'h12, 8'hA5, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h12, 8'h00, 0, 0, '0, '0);
    idle(3);
    // Contention for 4 cycles, then B alone so it always completes.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 6'h20, 8'h30 + 8'(i), 1, 1, 6'h21, 8'h40);
    applyStimulus(0, 0, '0, '0, 1, 1, 6'h21, 8'h40);
    // Interleaved reads from both requesters.
    applyStimulus(1, 1, 6'h01, 8'h11, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 1, 6'h02, 8'h22);
    applyStimulus(1, 0, 6'h01, 8'h00, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 6'h02, 8'h00);
    idle(3);
    // Boundary addresses.
    applyStimulus(1, 1, 6'h3F, 8'hFF, 0, 0, '0, '0);
    applyStimulus(1, 1, 6'h00, 8'h00, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h3F, 8'h00, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h00, 8'h00, 0, 0, '0, '0);
    idle(3);
    // Reset one cycle after a read grant: that read must never return.
    applyStimulus(1, 1, 6'h07, 8'h5A, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h07, 8'h00, 0, 0, '0, '0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(4);
    // Randomised traffic that respects the hold-until-granted rule.
    for (int i = 0; i < 400; i++) begin
      logic ar, awe, br, bwe;
      logic [AW-1:0] aa, ba;
      logic [DW-1:0] ad, bd;
      ar = a_req; awe = a_we; aa = a_addr; ad = a_wdata;
      br = b_req; bwe = b_we; ba = b_addr; bd = b_wdata;
      if (!a_req || a_xfer) begin
        ar = ($urandom_range(0, 3) != 0);
        awe = 1'($urandom_range(0, 1));
        aa = pool[$urandom_range(0, 8)];
        ad = 8'($urandom);
      end
      if (!b_req || b_xfer) begin
        br = ($urandom_range(0, 3) != 0);
        bwe = 1'($urandom_range(0, 1));
        ba = pool[$urandom_range(0, 8)];
        bd = 8'($urandom);
      end
      applyStimulus(ar, awe, aa, ad, br, bwe, ba, bd);
    end
    idle(6);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
